// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared types and constants for the ID issue stage: forward
//             codes, FSM states, word type. Honours WB_LOAD_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  fwd_t;

  localparam fwd_t FWD_RF     = 3'd0;
  localparam fwd_t FWD_EX_ALU = 3'd1;
  localparam fwd_t FWD_ME_ALU = 3'd2;
  localparam fwd_t FWD_WB_ALU = 3'd3;
  localparam fwd_t FWD_EX_LD  = 3'd4;
  localparam fwd_t FWD_ME_LD  = 3'd5;
  localparam fwd_t FWD_WB_LD  = 3'd6;
  localparam fwd_t FWD_RSVD   = 3'd7;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_CP0_WAIT = 1'b1
  } state_e;

  // Without the WB load bypass a WB-stage load must wait one cycle for the
  // register-file write-before-read.
  function automatic logic fwd_is_load_hazard(input fwd_t code);
`ifdef WB_LOAD_BYPASS_EN
    return (code == FWD_EX_LD) || (code == FWD_ME_LD);
`else
    return (code == FWD_EX_LD) || (code == FWD_ME_LD) || (code == FWD_WB_LD);
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_issue_stage_if.sv
// ============================================================================
//  Module   : id_issue_stage_if
//  Brief    : Decode/forwarding/EX-register bundle of the ID issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_issue_stage_if;
  import cpu_pkg::*;

  logic  flush;
  logic  id_valid;
  logic  id_ready;
  logic  id_op_mtc0;
  logic  id_is_load;
  logic  [4:0] id_dst;
  word_t rf_rdata_a;
  word_t rf_rdata_b;
  fwd_t  fwd_a;
  fwd_t  fwd_b;
  word_t ex_result;
  word_t me_result;
  word_t wb_result;
  word_t wb_load_data;
  logic  ex_allowin;
  logic  ex_valid;
  word_t ex_src_a;
  word_t ex_src_b;
  logic  [4:0] ex_dst_o;
  logic  ex_is_load_o;

  modport slave (
    input  flush, id_valid, id_op_mtc0, id_is_load, id_dst,
           rf_rdata_a, rf_rdata_b, fwd_a, fwd_b,
           ex_result, me_result, wb_result, wb_load_data, ex_allowin,
    output id_ready, ex_valid, ex_src_a, ex_src_b, ex_dst_o, ex_is_load_o
  );

  modport master (
    output flush, id_valid, id_op_mtc0, id_is_load, id_dst,
           rf_rdata_a, rf_rdata_b, fwd_a, fwd_b,
           ex_result, me_result, wb_result, wb_load_data, ex_allowin,
    input  id_ready, ex_valid, ex_src_a, ex_src_b, ex_dst_o, ex_is_load_o
  );

endinterface

`default_nettype wire

// File: rtl/operand_bypass_mux.sv
// ============================================================================
//  Module   : operand_bypass_mux
//  Brief    : Forward-code to operand selection plus load-use hazard flag.
//             WB_LOAD_BYPASS_EN adds the wb_load_data path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_bypass_mux
  import cpu_pkg::*;
(
  input  fwd_t  fwd_i,
  input  word_t rf_rdata_i,
  input  word_t ex_result_i,
  input  word_t me_result_i,
  input  word_t wb_result_i,
`ifdef WB_LOAD_BYPASS_EN
  input  word_t wb_load_data_i,
`endif
  output word_t operand_o,
  output logic  hazard_o
);

  always_comb begin
    operand_o = rf_rdata_i;
    case (fwd_i)
      FWD_EX_ALU: operand_o = ex_result_i;
      FWD_ME_ALU: operand_o = me_result_i;
      FWD_WB_ALU: operand_o = wb_result_i;
`ifdef WB_LOAD_BYPASS_EN
      FWD_WB_LD:  operand_o = wb_load_data_i;
`endif
      default:    operand_o = rf_rdata_i;
    endcase
  end

  assign hazard_o = fwd_is_load_hazard(fwd_i);

endmodule

`default_nettype wire

// File: rtl/id_issue_stage.sv
// ============================================================================
//  Module   : id_issue_stage
//  Brief    : ID-to-EX issue: operand bypass, load-use / mtc0 stalls and the
//             ID/EX register. Optional macro: WB_LOAD_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_issue_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CP0_STALL = 2
)(
  input  logic               clk,
  input  logic               reset,
  id_issue_stage_if.slave    bus
);

  localparam logic [2:0] C_CP0_STALL = 3'(CP0_STALL);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ex_valid_q, ex_valid_d;
  word_t      ex_src_a_q, ex_src_a_d;
  word_t      ex_src_b_q, ex_src_b_d;
  logic [4:0] ex_dst_q, ex_dst_d;
  logic       ex_is_load_q, ex_is_load_d;

  word_t w_operand_a, w_operand_b;
  logic  w_hazard_a, w_hazard_b, w_hazard;
  logic  w_id_ready;

  operand_bypass_mux u_mux_a (
    .fwd_i          (bus.fwd_a),
    .rf_rdata_i     (bus.rf_rdata_a),
    .ex_result_i    (bus.ex_result),
    .me_result_i    (bus.me_result),
    .wb_result_i    (bus.wb_result),
`ifdef WB_LOAD_BYPASS_EN
    .wb_load_data_i (bus.wb_load_data),
`endif
    .operand_o      (w_operand_a),
    .hazard_o       (w_hazard_a)
  );

  operand_bypass_mux u_mux_b (
    .fwd_i          (bus.fwd_b),
    .rf_rdata_i     (bus.rf_rdata_b),
    .ex_result_i    (bus.ex_result),
    .me_result_i    (bus.me_result),
    .wb_result_i    (bus.wb_result),
`ifdef WB_LOAD_BYPASS_EN
    .wb_load_data_i (bus.wb_load_data),
`endif
    .operand_o      (w_operand_b),
    .hazard_o       (w_hazard_b)
  );

  assign w_hazard = w_hazard_a | w_hazard_b;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ex_valid_d   = ex_valid_q;
    ex_src_a_d   = ex_src_a_q;
    ex_src_b_d   = ex_src_b_q;
    ex_dst_d     = ex_dst_q;
    ex_is_load_d = ex_is_load_q;
    w_id_ready   = 1'b0;

    if (bus.flush) begin
      ex_valid_d = 1'b0;
      state_d    = ST_RUN;
      cnt_d      = 3'd0;
    end else if (bus.ex_allowin) begin
      // A stalled EX (ex_allowin low) leaves every field and the counter untouched.
      case (state_q)
        ST_RUN: begin
          ex_valid_d = 1'b0;
          if (bus.id_valid && !w_hazard && !reset) begin
            w_id_ready   = 1'b1;
            ex_valid_d   = 1'b1;
            ex_src_a_d   = w_operand_a;
            ex_src_b_d   = w_operand_b;
            ex_dst_d     = bus.id_dst;
            ex_is_load_d = bus.id_is_load;
            if (bus.id_op_mtc0) begin
              state_d = ST_CP0_WAIT;
              cnt_d   = C_CP0_STALL;
            end
          end
        end
        ST_CP0_WAIT: begin
          ex_valid_d = 1'b0;
          if (cnt_q <= 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= 3'd0;
      ex_valid_q   <= 1'b0;
      ex_src_a_q   <= '0;
      ex_src_b_q   <= '0;
      ex_dst_q     <= 5'd0;
      ex_is_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_src_a_q   <= ex_src_a_d;
      ex_src_b_q   <= ex_src_b_d;
      ex_dst_q     <= ex_dst_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign bus.id_ready     = w_id_ready;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_src_a     = ex_src_a_q;
  assign bus.ex_src_b     = ex_src_b_q;
  assign bus.ex_dst_o     = ex_dst_q;
  assign bus.ex_is_load_o = ex_is_load_q;

endmodule

`default_nettype wire

// File: tb/tb_id_issue_stage.sv
// ============================================================================
//  Module   : tb_id_issue_stage
//  Brief    : Self-checking bench for id_issue_stage (vector table, directed
//             stall sequences, random stimulus vs. reference model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_issue_stage;
  import cpu_pkg::*;

  localparam int CP0_STALL = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_issue_stage_if bus();

  id_issue_stage #(.CP0_STALL(CP0_STALL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: EX register contents and remaining mtc0 bubbles.
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_dst;
  logic        m_ld;
  int          m_cp0_left;

  function automatic logic ref_hazard(input logic [2:0] c);
`ifdef WB_LOAD_BYPASS_EN
    return (c == 3'd4) || (c == 3'd5);
`else
    return (c == 3'd4) || (c == 3'd5) || (c == 3'd6);
`endif
  endfunction

  function automatic logic [31:0] ref_operand(input logic [2:0] c, input logic [31:0] rf);
    case (c)
      3'd1:    return bus.ex_result;
      3'd2:    return bus.me_result;
      3'd3:    return bus.wb_result;
`ifdef WB_LOAD_BYPASS_EN
      3'd6:    return bus.wb_load_data;
`endif
      default: return rf;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_dst = '0; m_ld = 1'b0; m_cp0_left = 0;
  endtask

  task automatic drive(input logic v, input logic m, input logic [2:0] fa, input logic [2:0] fb,
                       input logic allow, input logic fl);
    bus.id_valid = v; bus.id_op_mtc0 = m; bus.fwd_a = fa; bus.fwd_b = fb;
    bus.ex_allowin = allow; bus.flush = fl;
  endtask

  task automatic rand_data();
    bus.rf_rdata_a = $urandom; bus.rf_rdata_b = $urandom;
    bus.ex_result = $urandom; bus.me_result = $urandom; bus.wb_result = $urandom;
    bus.wb_load_data = $urandom;
    bus.id_dst = 5'($urandom); bus.id_is_load = 1'($urandom);
  endtask

  // One clock: check id_ready before the edge, then every EX output after it.
  task automatic cycle(output logic dut_rdy);
    logic hz, rdy;
    logic [31:0] na, nb;
    #1;
    hz  = ref_hazard(bus.fwd_a) || ref_hazard(bus.fwd_b);
    rdy = !bus.flush && (m_cp0_left == 0) && bus.id_valid && bus.ex_allowin && !hz;
    dut_rdy = bus.id_ready;
    chk("id_ready", 32'(bus.id_ready), 32'(rdy));
    na = ref_operand(bus.fwd_a, bus.rf_rdata_a);
    nb = ref_operand(bus.fwd_b, bus.rf_rdata_b);
    @(posedge clk);
    #1;
    if (bus.flush) begin
      m_valid = 1'b0; m_cp0_left = 0;
    end else if (bus.ex_allowin) begin
      if (m_cp0_left > 0) begin
        m_valid = 1'b0; m_cp0_left--;
      end else if (rdy) begin
        m_valid = 1'b1; m_a = na; m_b = nb; m_dst = bus.id_dst; m_ld = bus.id_is_load;
        if (bus.id_op_mtc0) m_cp0_left = CP0_STALL;
      end else begin
        m_valid = 1'b0;
      end
    end
    chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("ex_src_a", bus.ex_src_a, m_a);
    chk("ex_src_b", bus.ex_src_b, m_b);
    chk("ex_dst_o", 32'(bus.ex_dst_o), 32'(m_dst));
    chk("ex_is_load_o", 32'(bus.ex_is_load_o), 32'(m_ld));
  endtask

  typedef struct {
    logic [2:0]  fa, fb;
    logic        exp_rdy;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic r;
    logic [31:0] saved;
    logic [2:0]  lu_seq[4];
    logic        lu_exp[4];
    int          lu_len;

    // Reset state, with id_valid already high to show id_ready is held low.
    reset = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    rand_data();
    model_reset();
    #2;
    chk("rst_id_ready", 32'(bus.id_ready), 32'd0);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ex_src_a", bus.ex_src_a, 32'd0);
    chk("rst_ex_src_b", bus.ex_src_b, 32'd0);
    chk("rst_ex_dst", 32'(bus.ex_dst_o), 32'd0);
    chk("rst_ex_is_load", 32'(bus.ex_is_load_o), 32'd0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;

    // Vector table with fixed stage data.
    bus.rf_rdata_a = 32'hA000_0001; bus.rf_rdata_b = 32'hB000_0002;
    bus.ex_result  = 32'h0000_1234; bus.me_result  = 32'hD000_0004;
    bus.wb_result  = 32'hC000_0005; bus.wb_load_data = 32'hDEAD_BEEF;
    bus.id_dst = 5'd7; bus.id_is_load = 1'b0;
    tbl[0] = '{3'd1, 3'd0, 1'b1, 32'h0000_1234, 32'hB000_0002};
    tbl[1] = '{3'd2, 3'd3, 1'b1, 32'hD000_0004, 32'hC000_0005};
    tbl[2] = '{3'd3, 3'd1, 1'b1, 32'hC000_0005, 32'h0000_1234};
    tbl[3] = '{3'd0, 3'd2, 1'b1, 32'hA000_0001, 32'hD000_0004};
    tbl[4] = '{3'd7, 3'd7, 1'b1, 32'hA000_0001, 32'hB000_0002};
    tbl[5] = '{3'd4, 3'd0, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{3'd0, 3'd5, 1'b0, 32'h0, 32'h0};
`ifdef WB_LOAD_BYPASS_EN
    tbl[7] = '{3'd6, 3'd6, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
`else
    tbl[7] = '{3'd6, 3'd6, 1'b0, 32'h0, 32'h0};
`endif
    tbl[8] = '{3'd1, 3'd1, 1'b1, 32'h0000_1234, 32'h0000_1234};
    foreach (tbl[i]) begin
      drive(1'b1, 1'b0, tbl[i].fa, tbl[i].fb, 1'b1, 1'b0);
      cycle(r);
      chk("tbl_ready", 32'(r), 32'(tbl[i].exp_rdy));
      chk("tbl_valid", 32'(bus.ex_valid), 32'(tbl[i].exp_rdy));
      if (tbl[i].exp_rdy) begin
        chk("tbl_src_a", bus.ex_src_a, tbl[i].exp_a);
        chk("tbl_src_b", bus.ex_src_b, tbl[i].exp_b);
      end
    end

    // Load-use: forward code walks EX -> ME -> WB (-> RF without bypass).
    lu_seq[0] = 3'd4; lu_seq[1] = 3'd5; lu_seq[2] = 3'd6; lu_seq[3] = 3'd0;
    lu_exp[0] = 1'b0; lu_exp[1] = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    lu_exp[2] = 1'b1; lu_len = 3;
`else
    lu_exp[2] = 1'b0; lu_exp[3] = 1'b1; lu_len = 4;
    bus.rf_rdata_b = 32'hDEAD_BEEF;
`endif
    for (int i = 0; i < lu_len; i++) begin
      drive(1'b1, 1'b0, 3'd0, lu_seq[i], 1'b1, 1'b0);
      cycle(r);
      chk("lu_valid", 32'(bus.ex_valid), 32'(lu_exp[i]));
    end
    chk("lu_src_b", bus.ex_src_b, 32'hDEAD_BEEF);

    // mtc0 followed by a held dependent instruction: ex_valid 1,0,0,1.
    drive(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0);
    cycle(r);
    chk("mtc0_ready", 32'(r), 32'd1);
    chk("mtc0_valid", 32'(bus.ex_valid), 32'd1);
    bus.id_op_mtc0 = 1'b0;
    for (int i = 0; i < CP0_STALL; i++) begin
      cycle(r);
      chk("cp0_ready", 32'(r), 32'd0);
      chk("cp0_bubble", 32'(bus.ex_valid), 32'd0);
    end
    cycle(r);
    chk("cp0_resume_ready", 32'(r), 32'd1);
    chk("cp0_resume_valid", 32'(bus.ex_valid), 32'd1);

    // ex_allowin low for 3 cycles inside CP0_WAIT freezes EX and the counter.
    bus.id_op_mtc0 = 1'b1;
    cycle(r);
    saved = bus.ex_src_a;
    bus.id_op_mtc0 = 1'b0;
    bus.ex_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle(r);
      chk("frz_valid", 32'(bus.ex_valid), 32'd1);
      chk("frz_src_a", bus.ex_src_a, saved);
    end
    bus.ex_allowin = 1'b1;
    for (int i = 0; i < CP0_STALL; i++) begin
      cycle(r);
      chk("frz_bubble", 32'(bus.ex_valid), 32'd0);
    end
    cycle(r);
    chk("frz_resume", 32'(bus.ex_valid), 32'd1);

    // Flush during a load stall.
    drive(1'b1, 1'b0, 3'd4, 3'd0, 1'b1, 1'b1);
    cycle(r);
    chk("flush_ready", 32'(r), 32'd0);
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);

    // Reset in CP0_WAIT with one bubble left.
    drive(1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0);
    cycle(r);
    bus.id_op_mtc0 = 1'b0;
    cycle(r);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_src_a", bus.ex_src_a, 32'd0);
    chk("arst_src_b", bus.ex_src_b, 32'd0);
    chk("arst_dst", 32'(bus.ex_dst_o), 32'd0);
    chk("arst_ready", 32'(bus.id_ready), 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    bus.rf_rdata_a = 32'h1357_9BDF;
    drive(1'b1, 1'b0, 3'd6, 3'd0, 1'b1, 1'b0);
    cycle(r);
`ifdef WB_LOAD_BYPASS_EN
    chk("post_rst_wbld", 32'(bus.ex_valid), 32'd1);
`else
    chk("post_rst_wbld", 32'(bus.ex_valid), 32'd0);
`endif
    bus.fwd_a = 3'd0;
    cycle(r);
    chk("post_rst_valid", 32'(bus.ex_valid), 32'd1);
    chk("post_rst_src_a", bus.ex_src_a, 32'h1357_9BDF);

    // Random traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      rand_data();
      drive(($urandom % 4) != 0, ($urandom % 8) == 0,
            ($urandom % 2) ? 3'd0 : 3'($urandom), ($urandom % 2) ? 3'd0 : 3'($urandom),
            ($urandom % 5) != 0, ($urandom % 20) == 0);
      cycle(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_issue_stage.md
# id_issue_stage

Decode-to-execute issue stage of the five-stage MIPS pipeline, sitting directly downstream of the forwarding unit. It consumes the per-operand 3-bit forward codes and the stage results, selects bypassed source operands, and detects load-use and CP0-write hazards. Internally it sequences the resulting stalls and registers the issued instruction into the ID/EX pipeline register under a valid/allow-in handshake.

## Interface
Parameters:
- CP0_STALL, 2: bubble cycles inserted after an issued mtc0 (range 1..7).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  exception/eret flush; kills ID and the EX register.
- id_valid  in  1  ID holds a valid decoded instruction.
- id_ready  out  1  ID instruction accepted this cycle.
- id_op_mtc0  in  1  ID instruction is mtc0.
- id_is_load  in  1  ID instruction is a load (passed to EX).
- id_dst  in  5  destination register (passed to EX).
- rf_rdata_a / rf_rdata_b  in  32  register-file read data.
- fwd_a / fwd_b  in  3  forward code: 0=regfile, 1/2/3=ALU result in EX/ME/WB, 4/5/6=load in EX/ME/WB.
- ex_result / me_result / wb_result  in  32  ALU results per stage.
- wb_load_data  in  32  aligned load data, valid in WB.
- ex_allowin  in  1  EX can accept a new entry.
- ex_valid  out  1  EX register valid.
- ex_src_a / ex_src_b  out  32  registered operands.
- ex_dst_o  out  5  registered destination.
- ex_is_load_o  out  1  registered load flag.

## Operation
- Operand select per operand: code 0 -> rf_rdata, 1 -> ex_result, 2 -> me_result, 3 -> wb_result, 6 -> wb_load_data, 7 -> rf_rdata.
- Load hazard: fwd code 4 or 5 on either operand (also 6 without the macro, see Configuration).
- FSM states: RUN, CP0_WAIT.
- RUN: id_ready = id_valid & ex_allowin & ~hazard & ~flush. On accept, the EX register loads operands, id_dst, id_is_load, and ex_valid<=1. If id_valid & ex_allowin & hazard, a bubble is inserted (ex_valid<=0) and ID holds; hazard is re-evaluated every cycle as the forward codes advance. Accept of an instruction with id_op_mtc0 -> CP0_WAIT, cnt<=CP0_STALL.
- CP0_WAIT: id_ready=0; each cycle with ex_allowin, insert a bubble and decrement cnt; when cnt reaches 1 and ex_allowin, go to RUN.
- ex_allowin=0: the EX register holds all fields, including ex_valid; cnt is frozen.
- flush (highest priority): ex_valid<=0, state<=RUN, cnt<=0, id_ready=0.
- cnt width: 3 bits, unsigned, no wrap (saturates at 0).

## Timing
- Reset values: ex_valid=0, ex_src_a=ex_src_b=0, ex_dst_o=0, ex_is_load_o=0, state=RUN, cnt=0. id_ready is 0 while reset is asserted.
- Issue latency: 1 cycle (accept at edge N -> ex_valid/operands visible after N).
- Load in EX at ID time: 2 bubbles. Load in ME: 1 bubble. Load in WB: 0 bubbles with macro, 1 without.
- mtc0 followed by a dependent instruction: exactly CP0_STALL bubbles when ex_allowin stays high.
- Reset mid-stall clears the state asynchronously; the first accept is possible in the cycle after reset deassertion.
- flush and hazard in the same cycle: flush wins, and no bubble counting occurs.

## Configuration
- WB_LOAD_BYPASS_EN defined: code 6 selects wb_load_data with no stall.
- Not defined: code 6 is treated as a hazard, giving a 1-cycle stall; the operand is then read from the register file (write-before-read) and the wb_load_data path is removed.

## Structure
- Shared package cpu_pkg holds the forward-code constants (FWD_RF, FWD_EX_ALU … FWD_WB_LD), the FSM state enum, and the 32-bit word type.
- One natural sub-module, operand_bypass_mux, is instantiated twice (A/B). It is combinational code-to-data selection plus a per-operand hazard flag.

## Test plan
- add with fwd_a=1, ex_result=0x0000_1234, ex_allowin=1 -> next cycle ex_valid=1, ex_src_a=0x0000_1234, zero bubbles.
- Load then dependent use: fwd_b=4, then 5, then 6 (with macro), wb_load_data=0xDEAD_BEEF -> two bubble cycles (ex_valid=0), then ex_src_b=0xDEAD_BEEF.
- mtc0 issue with CP0_STALL=2 and next id_valid held -> id_ready low for exactly 2 cycles, ex_valid pattern 1,0,0,1.
- ex_allowin=0 for 3 cycles during CP0_WAIT -> cnt frozen, EX register unchanged, stall completes after allow-in resumes.
- flush asserted during a load stall with fwd_a=4 -> ex_valid=0 next cycle, state RUN, id_ready=0 in the flush cycle.
- reset asserted mid-CP0_WAIT with cnt=1 -> all outputs return to reset values immediately; without the macro, fwd_a=6 yields 1 bubble, then ex_src_a=rf_rdata_a.
